// File: rtl/sub_pipe_nbit_if.sv
`default_nettype none
// ============================================================================
//  Module   : sub_pipe_nbit_if
//  Brief    : Valid/ready operand and result bundle for the pipelined add/sub unit.
//  Revision : 1.0
// ============================================================================
interface sub_pipe_nbit_if #(
    parameter int WIDTH = 256
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, mode, din1, din2, bin, out_ready,
        input  in_ready, out_valid, dout, bout, ovf
    );

    modport slave (
        input  in_valid, mode, din1, din2, bin, out_ready,
        output in_ready, out_valid, dout, bout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/sub_pipe_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : sub_pipe_nbit
//  Brief    : Segmented, pipelined WIDTH-bit add/subtract, one segment per stage.
//  Revision : 1.0
// ============================================================================
module sub_pipe_nbit #(
    parameter int WIDTH     = 256,
    parameter int SEG_WIDTH = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sub_pipe_nbit_if.slave    bus
);
    localparam int NUM_SEG = WIDTH / SEG_WIDTH;

    if ((WIDTH % SEG_WIDTH) != 0 || NUM_SEG < 1) begin : g_bad_width
        $error("sub_pipe_nbit: WIDTH must be a nonzero multiple of SEG_WIDTH");
    end

    logic w_advance;
    logic w_out_valid;

    assign w_advance    = ~w_out_valid | bus.out_ready;
    assign bus.in_ready = rst | w_advance;

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        logic                 w_vld;
        logic                 w_mode;
        logic                 w_cin;
        logic [WIDTH-1:0]     w_a;
        logic [WIDTH-1:0]     w_b;
        logic [WIDTH-1:0]     w_res;
        logic [SEG_WIDTH-1:0] w_bx;
        logic                 w_ci;
        logic [SEG_WIDTH:0]   w_sum;
        logic                 w_cout;
        logic                 w_ovf;
        logic [WIDTH-1:0]     w_res_nx;

        logic                 r_vld;
        logic                 r_mode;
        logic                 r_c;
        logic                 r_ovf;
        logic [WIDTH-1:0]     r_a;
        logic [WIDTH-1:0]     r_b;
        logic [WIDTH-1:0]     r_res;

        if (k == 0) begin : g_head
            assign w_vld  = bus.in_valid;
            assign w_mode = bus.mode;
            assign w_cin  = bus.bin;
            assign w_a    = bus.din1;
            assign w_b    = bus.din2;
            assign w_res  = '0;
        end else begin : g_body
            assign w_vld  = g_stage[k-1].r_vld;
            assign w_mode = g_stage[k-1].r_mode;
            assign w_cin  = g_stage[k-1].r_c;
            assign w_a    = g_stage[k-1].r_a;
            assign w_b    = g_stage[k-1].r_b;
            assign w_res  = g_stage[k-1].r_res;
        end

        // Subtract runs as A + ~B + ~borrow, so the same adder serves both modes
        // and the carry out is the inverse of the borrow out.
        assign w_bx   = w_mode ? w_b[k*SEG_WIDTH +: SEG_WIDTH] : ~w_b[k*SEG_WIDTH +: SEG_WIDTH];
        assign w_ci   = w_mode ? w_cin : ~w_cin;
        assign w_sum  = {1'b0, w_a[k*SEG_WIDTH +: SEG_WIDTH]} + {1'b0, w_bx}
                      + {{SEG_WIDTH{1'b0}}, w_ci};
        assign w_cout = w_mode ? w_sum[SEG_WIDTH] : ~w_sum[SEG_WIDTH];

        // Only meaningful in the MSB stage, where w_bx holds the sign of B or ~B.
        assign w_ovf  = (w_a[WIDTH-1] == w_bx[SEG_WIDTH-1]) &
                        (w_sum[SEG_WIDTH-1] != w_a[WIDTH-1]);

        always_comb begin
            w_res_nx = w_res;
            w_res_nx[k*SEG_WIDTH +: SEG_WIDTH] = w_sum[SEG_WIDTH-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_mode <= 1'b0;
                r_c    <= 1'b0;
                r_ovf  <= 1'b0;
                r_a    <= '0;
                r_b    <= '0;
                r_res  <= '0;
            end else if (w_advance) begin
                r_vld  <= w_vld;
                r_mode <= w_mode;
                r_c    <= w_cout;
                r_ovf  <= w_ovf;
                r_a    <= w_a;
                r_b    <= w_b;
                r_res  <= w_res_nx;
            end
        end
    end

    assign w_out_valid   = g_stage[NUM_SEG-1].r_vld;
    assign bus.out_valid = w_out_valid;
    assign bus.dout      = g_stage[NUM_SEG-1].r_res;
    assign bus.bout      = g_stage[NUM_SEG-1].r_c;
    assign bus.ovf       = g_stage[NUM_SEG-1].r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_sub_pipe_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sub_pipe_nbit
//  Brief    : Directed self-checking bench for sub_pipe_nbit (256/64, latency 4).
//  Revision : 1.0
// ============================================================================
module tb_sub_pipe_nbit;
    localparam int W = 256;
    localparam int S = 64;
    localparam int N = W / S;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sub_pipe_nbit_if #(.WIDTH(W)) bus ();

    sub_pipe_nbit #(.WIDTH(W), .SEG_WIDTH(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int ncmp  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {ovf, bout, dout}, from full-width arithmetic.
    function automatic logic [W+1:0] model(input logic m, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic bi);
        logic [W:0] r;
        logic       o;
        if (m) begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bi};
            o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
            o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {o, r[W], r[W-1:0]};
    endfunction

    task automatic run_one(input string tag, input logic m, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic bi,
                           input logic [W-1:0] ed, input logic eb, input logic eo);
        int lat;
        bus.mode      = m;
        bus.din1      = a;
        bus.din2      = b;
        bus.bin       = bi;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, N);
        chk({tag, "_dout"}, bus.dout, ed);
        chk({tag, "_bout"}, bus.bout, eb);
        chk({tag, "_ovf"},  bus.ovf,  eo);
        @(posedge clk); #1;
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] one;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vm;
    logic         vbi;
    logic [W+1:0] expq[$];
    logic [W+1:0] held;
    logic         stalled_prev;
    int           sent;
    int           got;
    int           cyc;

    initial begin
        ones = '1;
        one  = 1;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.din1      = '0;
        bus.din2      = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_bout", bus.bout, 0);
        chk("rst_ovf",  bus.ovf,  0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);

        // Directed vectors
        run_one("sub_ripple", 1'b0, one << 192, one, 1'b0, (one << 192) - one, 1'b0, 1'b0);
        run_one("sub_zero_minus_one", 1'b0, '0, one, 1'b0, ones, 1'b1, 1'b0);
        run_one("sub_signed_ovf", 1'b0, one << 255, one, 1'b0, (one << 255) - one, 1'b0, 1'b1);
        run_one("add_wrap", 1'b1, ones, '0, 1'b1, '0, 1'b1, 1'b0);
        run_one("add_signed_ovf", 1'b1, ones >> 1, one, 1'b0, one << 255, 1'b0, 1'b1);
        run_one("sub_borrow_in", 1'b0, 256'd5, 256'd3, 1'b1, 256'd1, 1'b0, 1'b0);

        // Back-to-back random beats with out_ready toggling 1,0,1,0...
        sent = 0; got = 0; cyc = 0; stalled_prev = 1'b0; held = '0;
        while (got < 8 && cyc < 200) begin
            bus.out_ready = (cyc % 2 == 0);
            if (sent < 8) begin
                va  = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                vb  = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                vm  = 1'($urandom_range(0, 1));
                vbi = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
                bus.mode     = vm;
                bus.din1     = va;
                bus.din2     = vb;
                bus.bin      = vbi;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (stalled_prev) begin
                chk("stall_hold_valid", bus.out_valid, 1);
                chk("stall_hold_data", {bus.ovf, bus.bout, bus.dout}, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("stream_extra_beat", 1, 0);
                end else begin
                    chk("stream_result", {bus.ovf, bus.bout, bus.dout}, expq.pop_front());
                end
                got++;
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            held         = {bus.ovf, bus.bout, bus.dout};
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(model(vm, va, vb, vbi));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_count", got, 8);
        repeat (6) begin
            @(posedge clk); #1;
            chk("stream_drained", bus.out_valid, 0);
        end

        // Reset with three beats in flight
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.mode      = 1'b1;
        bus.din1      = 256'd7;
        bus.din2      = 256'd9;
        bus.bin       = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst_no_stale", bus.out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
`default_nettype wire
